// File: rtl/registrador_digitos_tempo.sv
// -----------------------------------------------------------------------------
// registrador_digitos_tempo
//
// Time-entry digit register fed by the keypad priority encoder. The key-valid
// flag is debounced for both press and release. Each confirmed press is
// accepted exactly once and shifted into a four-digit MM:SS register from the
// right, the way a microwave keypad works.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive edges dado_valido must hold a level to confirm
//                     a press or a release (2..255)
//
// Ports
//   clock           : system clock, rising edge
//   clearn          : asynchronous active-low reset
//   BCD[3:0]        : digit code from the encoder, sampled on the confirm edge
//   dado_valido     : key-valid flag, high while a key is held
//   loadn           : active-low entry enable (1 blocks new presses)
//   clr_digitos     : synchronous clear of digits and digit count
//   min_dez/min_uni/seg_dez/seg_uni[3:0] : stored digits, oldest to newest
//   num_digitos[2:0]: digits entered since clear, saturates at 4
//   digito_aceito   : one-cycle pulse, a digit was shifted in
//   digito_invalido : one-cycle pulse, a press was confirmed with BCD > 9
//   tempo_zero      : combinational, all four digits are zero
// -----------------------------------------------------------------------------
module registrador_digitos_tempo #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic [3:0] BCD,
  input  logic       dado_valido,
  input  logic       loadn,
  input  logic       clr_digitos,
  output logic [3:0] min_dez,
  output logic [3:0] min_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] seg_uni,
  output logic [2:0] num_digitos,
  output logic       digito_aceito,
  output logic       digito_invalido,
  output logic       tempo_zero
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    OCIOSO,
    CONFIRMA,
    PRESSIONADO,
    SOLTANDO
  } estado_t;

  estado_t          estado;
  logic [CNT_W-1:0] cnt;
  logic             confirma;
  logic             bcd_ok;

  function automatic logic [2:0] sat_inc(input logic [2:0] n);
    return (n >= 3'd4) ? 3'd4 : n + 3'd1;
  endfunction

  // The Nth consecutive qualifying sample is this edge itself: the state and
  // counter already hold N-1 earlier samples.
  assign confirma = (estado == CONFIRMA) && dado_valido && !loadn &&
                    (cnt == CNT_LAST);
  assign bcd_ok   = (BCD <= 4'd9);

  assign tempo_zero = (min_dez == 4'd0) && (min_uni == 4'd0) &&
                      (seg_dez == 4'd0) && (seg_uni == 4'd0);

  // Debounce FSM: press qualified by loadn, release ignores loadn and BCD so a
  // held key can never repeat.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      estado <= OCIOSO;
      cnt    <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (dado_valido && !loadn) begin
            estado <= CONFIRMA;
            cnt    <= CNT_ONE;
          end
        end
        CONFIRMA: begin
          if (!dado_valido || loadn) begin
            estado <= OCIOSO;
            cnt    <= '0;
          end else if (cnt == CNT_LAST) begin
            estado <= PRESSIONADO;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSIONADO: begin
          if (!dado_valido) begin
            estado <= SOLTANDO;
            cnt    <= CNT_ONE;
          end
        end
        SOLTANDO: begin
          if (dado_valido) begin
            estado <= PRESSIONADO;
            cnt    <= '0;
          end else if (cnt == CNT_LAST) begin
            estado <= OCIOSO;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          estado <= OCIOSO;
          cnt    <= '0;
        end
      endcase
    end
  end

  // Digit register: a clear wins over a simultaneous confirm, discarding that
  // digit and suppressing both pulses.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      min_dez         <= 4'd0;
      min_uni         <= 4'd0;
      seg_dez         <= 4'd0;
      seg_uni         <= 4'd0;
      num_digitos     <= 3'd0;
      digito_aceito   <= 1'b0;
      digito_invalido <= 1'b0;
    end else begin
      digito_aceito   <= 1'b0;
      digito_invalido <= 1'b0;
      if (clr_digitos) begin
        min_dez     <= 4'd0;
        min_uni     <= 4'd0;
        seg_dez     <= 4'd0;
        seg_uni     <= 4'd0;
        num_digitos <= 3'd0;
      end else if (confirma) begin
        if (bcd_ok) begin
          min_dez       <= min_uni;
          min_uni       <= seg_dez;
          seg_dez       <= seg_uni;
          seg_uni       <= BCD;
          num_digitos   <= sat_inc(num_digitos);
          digito_aceito <= 1'b1;
        end else begin
          digito_invalido <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_registrador_digitos_tempo.sv
module tb_registrador_digitos_tempo;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       clearn = 1'b0;
  logic [3:0] BCD = 4'd0;
  logic       dado_valido = 1'b0;
  logic       loadn = 1'b0;
  logic       clr_digitos = 1'b0;
  logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
  logic [2:0] num_digitos;
  logic       digito_aceito, digito_invalido, tempo_zero;

  int errors = 0;
  int checks = 0;

  registrador_digitos_tempo #(.DEBOUNCE_CYCLES(N)) dut (
    .clock          (clock),
    .clearn         (clearn),
    .BCD            (BCD),
    .dado_valido    (dado_valido),
    .loadn          (loadn),
    .clr_digitos    (clr_digitos),
    .min_dez        (min_dez),
    .min_uni        (min_uni),
    .seg_dez        (seg_dez),
    .seg_uni        (seg_uni),
    .num_digitos    (num_digitos),
    .digito_aceito  (digito_aceito),
    .digito_invalido(digito_invalido),
    .tempo_zero     (tempo_zero)
  );

  always #5 clock = ~clock;

  // Expected pulse events: kind, register contents after the event, and the
  // cycle in which the pulse must be visible.
  typedef struct {
    bit acc;
    int digits;
    int num;
    int cyc;
  } exp_t;
  exp_t q[$];

  // Reference model: the entry is a decimal number; a new digit is
  // value*10+d modulo 10000. A press is N consecutive enabled samples while
  // released; a release is N consecutive low samples while pressed.
  int m_digits = 0;
  int m_num    = 0;
  int m_run    = 0;
  bit m_pressed = 0;
  int cyc      = 0;

  always @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      m_digits  = 0;
      m_num     = 0;
      m_run     = 0;
      m_pressed = 0;
      q.delete();
    end else begin
      bit conf;
      exp_t e;
      conf = 0;
      cyc++;
      if (!m_pressed) begin
        m_run = (dado_valido && !loadn) ? m_run + 1 : 0;
        if (m_run == N) begin
          m_pressed = 1;
          m_run = 0;
          conf = 1;
        end
      end else begin
        m_run = (!dado_valido) ? m_run + 1 : 0;
        if (m_run == N) begin
          m_pressed = 0;
          m_run = 0;
        end
      end
      if (clr_digitos) begin
        m_digits = 0;
        m_num = 0;
      end else if (conf) begin
        if (BCD <= 9) begin
          m_digits = (m_digits * 10 + int'(BCD)) % 10000;
          m_num = (m_num < 4) ? m_num + 1 : 4;
          e.acc = 1;
        end else begin
          e.acc = 0;
        end
        e.digits = m_digits;
        e.num = m_num;
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  end

  function automatic int dut_digits();
    return int'(min_dez) * 1000 + int'(min_uni) * 100 +
           int'(seg_dez) * 10 + int'(seg_uni);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: compares each pulse against the scoreboard, including timing.
  always @(negedge clock) begin
    if (clearn) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_aceito", int'(digito_aceito), int'(e.acc));
        chk("pulse_invalido", int'(digito_invalido), int'(!e.acc));
        chk("pulse_digits", dut_digits(), e.digits);
        chk("pulse_num", int'(num_digitos), e.num);
      end else if (digito_aceito || digito_invalido) begin
        errors++;
        checks++;
        $display("FAIL unexpected_pulse: aceito=%0b invalido=%0b expected none (cycle %0d)",
                 digito_aceito, digito_invalido, cyc);
      end
    end
  end

  task automatic chk_model(input string tag);
    chk({tag, "_digits"}, dut_digits(), m_digits);
    chk({tag, "_num"}, int'(num_digitos), m_num);
    chk({tag, "_tempo_zero"}, int'(tempo_zero), int'(m_digits == 0));
  endtask

  task automatic press(input logic [3:0] d, input int hold, input int gap);
    BCD = d;
    dado_valido = 1'b1;
    repeat (hold) @(negedge clock);
    dado_valido = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_digits", dut_digits(), 0);
    chk("reset_num", int'(num_digitos), 0);
    chk("reset_aceito", int'(digito_aceito), 0);
    chk("reset_invalido", int'(digito_invalido), 0);
    chk("reset_tempo_zero", int'(tempo_zero), 1);
    clearn = 1'b1;
    @(negedge clock);

    // Keys 1,2,3,0
    press(4'd1, 10, 10);
    press(4'd2, 10, 10);
    press(4'd3, 10, 10);
    press(4'd0, 10, 10);
    chk("seq_min_dez", int'(min_dez), 1);
    chk("seq_min_uni", int'(min_uni), 2);
    chk("seq_seg_dez", int'(seg_dez), 3);
    chk("seq_seg_uni", int'(seg_uni), 0);
    chk("seq_num", int'(num_digitos), 4);

    // Full register keeps shifting
    press(4'd7, 10, 10);
    chk("full_digits", dut_digits(), 2307);
    chk("full_num", int'(num_digitos), 4);

    // Glitch shorter than N
    press(4'd9, N - 1, 10);
    chk("glitch_digits", dut_digits(), 2307);

    // Long hold with release bounce
    BCD = 4'd5;
    dado_valido = 1'b1;
    repeat (50) @(negedge clock);
    dado_valido = 1'b0;
    repeat (2) @(negedge clock);
    dado_valido = 1'b1;
    @(negedge clock);
    dado_valido = 1'b0;
    repeat (10) @(negedge clock);
    chk("bounce_seg_uni", int'(seg_uni), 5);
    chk("bounce_digits", dut_digits(), 3075);

    // Clear on the confirm edge of a press
    BCD = 4'd6;
    dado_valido = 1'b1;
    repeat (N - 1) @(negedge clock);
    clr_digitos = 1'b1;
    @(negedge clock);
    clr_digitos = 1'b0;
    repeat (5) @(negedge clock);
    dado_valido = 1'b0;
    repeat (10) @(negedge clock);
    chk("clr_digits", dut_digits(), 0);
    chk("clr_num", int'(num_digitos), 0);
    chk("clr_tempo_zero", int'(tempo_zero), 1);

    // Entry disabled
    loadn = 1'b1;
    press(4'd9, 20, 10);
    loadn = 1'b0;
    chk("loadn_digits", dut_digits(), 0);
    chk("loadn_num", int'(num_digitos), 0);

    // Invalid code
    press(4'hF, 10, 10);
    chk_model("invalid");

    // Async reset mid-debounce, key kept held afterwards
    press(4'd8, 10, 10);
    chk("pre_reset_seg_uni", int'(seg_uni), 8);
    BCD = 4'd2;
    dado_valido = 1'b1;
    repeat (2) @(negedge clock);
    clearn = 1'b0;
    #1;
    chk("async_digits", dut_digits(), 0);
    chk("async_num", int'(num_digitos), 0);
    chk("async_tempo_zero", int'(tempo_zero), 1);
    @(negedge clock);
    clearn = 1'b1;
    repeat (10) @(negedge clock);
    dado_valido = 1'b0;
    repeat (10) @(negedge clock);
    chk("after_reset_seg_uni", int'(seg_uni), 2);
    chk("after_reset_num", int'(num_digitos), 1);

    // Randomized presses, bounces, loadn, clears and key changes
    for (int i = 0; i < 60; i++) begin
      int hold;
      int gap;
      hold = $urandom_range(1, 12);
      gap  = $urandom_range(1, 10);
      BCD = 4'($urandom_range(0, 11));
      loadn = ($urandom_range(0, 7) == 0);
      dado_valido = 1'b1;
      for (int k = 0; k < hold; k++) begin
        clr_digitos = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 9) == 0) BCD = 4'($urandom_range(0, 15));
        @(negedge clock);
      end
      clr_digitos = 1'b0;
      dado_valido = 1'b0;
      repeat (gap) @(negedge clock);
      if (i % 10 == 9) chk_model("random");
    end
    loadn = 1'b0;
    repeat (12) @(negedge clock);
    chk_model("final");
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
